// File: rtl/pixel_line_pkg.sv
// Shared types and the lane extension helper for the ping-pong pixel line buffer.
package pixel_line_pkg;

    localparam int NUM_PIXELS_DEF = 160;
    localparam int LANES_DEF      = 4;
    localparam int IN_PIX_W_DEF   = 8;
    localparam int PIX_W_DEF      = 9;

    typedef logic [PIX_W_DEF-1:0]                      pixel_t;
    typedef pixel_t [NUM_PIXELS_DEF-1:0]               line_t;

    // Extends the low in_w bits of in_pix to 32 bits; callers truncate to their pixel width.
    function automatic logic [31:0] extend_pix(input logic [31:0] in_pix,
                                               input int          in_w,
                                               input logic        sign_ext);
        logic [31:0] mask;
        logic [31:0] res;
        mask = (32'd1 << in_w) - 32'd1;
        res  = in_pix & mask;
        if (sign_ext && (((in_pix >> (in_w - 1)) & 32'd1) != 32'd0))
            res = res | ~mask;
        return res;
    endfunction

endpackage

// File: rtl/pixel_line_bank.sv
// One line bank: LANES pixels written per word starting at a base index,
// lanes past the end of the line dropped, whole-bank clear.
module pixel_line_bank
    import pixel_line_pkg::*;
#(
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int LANES      = LANES_DEF,
    parameter int IN_PIX_W   = IN_PIX_W_DEF,
    parameter int PIX_W      = PIX_W_DEF,
    parameter int PTR_W      = $clog2(NUM_PIXELS + LANES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_we,
    input  logic                         i_clr,
    input  logic                         i_sign_ext,
    input  logic [PTR_W-1:0]             i_base,
    input  logic [LANES*IN_PIX_W-1:0]    i_data,
    output logic [NUM_PIXELS*PIX_W-1:0]  o_line
);

    logic [LANES-1:0][PTR_W-1:0] w_idx;
    logic [LANES-1:0][PIX_W-1:0] w_ext;
    logic [LANES-1:0]            w_lane_en;

    // base + lane never exceeds NUM_PIXELS+LANES-2, so PTR_W bits cannot wrap.
    always_comb begin
        w_idx     = '0;
        w_ext     = '0;
        w_lane_en = '0;
        for (int k = 0; k < LANES; k++) begin
            w_idx[k]     = i_base + PTR_W'(k);
            w_lane_en[k] = i_we & (w_idx[k] < PTR_W'(NUM_PIXELS));
            w_ext[k]     = PIX_W'(extend_pix(32'(i_data[k*IN_PIX_W +: IN_PIX_W]),
                                             IN_PIX_W, i_sign_ext));
        end
    end

    for (genvar gi = 0; gi < NUM_PIXELS; gi++) begin : g_pix
        localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);
        logic [PIX_W-1:0] r_q;
        logic [PIX_W-1:0] w_nxt;
        logic             w_hit;

        always_comb begin
            w_hit = 1'b0;
            w_nxt = r_q;
            for (int k = 0; k < LANES; k++) begin
                if (w_lane_en[k] && (w_idx[k] == IDX)) begin
                    w_hit = 1'b1;
                    w_nxt = w_ext[k];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_q <= '0;
            else if (i_clr)
                r_q <= '0;
            else if (w_hit)
                r_q <= w_nxt;
        end

        assign o_line[gi*PIX_W +: PIX_W] = r_q;
    end

endmodule

// File: rtl/pixel_line_pingpong.sv
// Ping-pong line buffer: words fill one bank while the other, once complete,
// is presented downstream until acknowledged.
module pixel_line_pingpong
    import pixel_line_pkg::*;
#(
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int LANES      = LANES_DEF,
    parameter int IN_PIX_W   = IN_PIX_W_DEF,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clean,
    input  logic                                sign_ext,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [LANES*IN_PIX_W-1:0]           data_in,
    output logic                                line_valid,
    input  logic                                line_ack,
    output logic [NUM_PIXELS*PIX_W-1:0]         data_out,
    output logic [$clog2(NUM_PIXELS+1)-1:0]     fill_level
);

    localparam int PTR_W = $clog2(NUM_PIXELS + LANES);
    localparam int FL_W  = $clog2(NUM_PIXELS + 1);

    logic [1:0]       r_full;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [PTR_W-1:0] r_wr_ptr;

    logic             w_accept;
    logic             w_last;
    logic             w_ack;
    logic             w_clear_wr;
    logic [PTR_W:0]   w_ptr_sum;
    logic [1:0]       w_full_nxt;
    logic [1:0][NUM_PIXELS*PIX_W-1:0] w_line;

    assign in_ready   = ~r_full[r_wr_bank] & ~clean;
    assign w_accept   = in_valid & in_ready;
    assign w_ptr_sum  = {1'b0, r_wr_ptr} + (PTR_W+1)'(LANES);
    assign w_last     = w_ptr_sum >= (PTR_W+1)'(NUM_PIXELS);
    assign w_ack      = line_ack & r_full[r_rd_bank];
    // A full write bank is the one being presented, so clean must not touch it.
    assign w_clear_wr = clean & ~r_full[r_wr_bank];

    // Completion and ack can never hit the same bank: accept needs it empty, ack needs it full.
    always_comb begin
        w_full_nxt = r_full;
        if (w_accept && w_last)
            w_full_nxt[r_wr_bank] = 1'b1;
        if (w_ack)
            w_full_nxt[r_rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_ptr  <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (clean) begin
                r_wr_ptr <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_wr_ptr  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_ptr  <= w_ptr_sum[PTR_W-1:0];
                end
            end
            if (w_ack)
                r_rd_bank <= ~r_rd_bank;
        end
    end

    for (genvar gb = 0; gb < 2; gb++) begin : g_bank
        logic w_sel;
        assign w_sel = (r_wr_bank == 1'(gb));

        pixel_line_bank #(
            .NUM_PIXELS (NUM_PIXELS),
            .LANES      (LANES),
            .IN_PIX_W   (IN_PIX_W),
            .PIX_W      (PIX_W),
            .PTR_W      (PTR_W)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_we       (w_accept & w_sel),
            .i_clr      (w_clear_wr & w_sel),
            .i_sign_ext (sign_ext),
            .i_base     (r_wr_ptr),
            .i_data     (data_in),
            .o_line     (w_line[gb])
        );
    end

    assign line_valid = r_full[r_rd_bank];
    assign data_out   = w_line[r_rd_bank];
    assign fill_level = (r_wr_ptr >= PTR_W'(NUM_PIXELS)) ? FL_W'(NUM_PIXELS)
                                                         : FL_W'(r_wr_ptr);

endmodule

// File: tb/tb_pixel_line_pingpong.sv
// Scoreboard bench: a line-level model queues completed lines, a monitor compares the presented line.
module tb_pixel_line_pingpong;

    localparam int NP = 10;
    localparam int LN = 4;
    localparam int IW = 8;
    localparam int PW = 9;
    localparam int LW = NP * PW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clean = 1'b0;
    logic            sign_ext = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [LN*IW-1:0] data_in = '0;
    logic            line_valid;
    logic            line_ack = 1'b0;
    logic [LW-1:0]   data_out;
    logic [$clog2(NP+1)-1:0] fill_level;

    pixel_line_pingpong #(.NUM_PIXELS(NP), .LANES(LN), .IN_PIX_W(IW), .PIX_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .clean(clean), .sign_ext(sign_ext),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .line_valid(line_valid), .line_ack(line_ack), .data_out(data_out),
        .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_mode = 0;   // 0 none, 1 random, 2 single ack

    // Reference model: current partial line plus FIFO of completed lines.
    logic [PW-1:0] m_cur [NP];
    logic [LW-1:0] m_q [$];
    int            m_cnt = 0;
    int            acc_cnt = 0;

    function automatic logic [PW-1:0] ext_ref(input logic [IW-1:0] v, input logic se);
        int x;
        x = int'(v);
        if (se && x >= 128) x = x - 256;
        return PW'(x);
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < NP; i++) m_cur[i] = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_cnt = 0;
            end else begin
                bit acc, ack;
                logic [LW-1:0] l;
                acc = in_valid && (m_q.size() < 2) && !clean;
                ack = line_ack && (m_q.size() > 0);
                if (ack) void'(m_q.pop_front());
                if (clean) begin
                    m_cnt = 0;
                end else if (acc) begin
                    for (int k = 0; k < LN; k++)
                        if (m_cnt + k < NP)
                            m_cur[m_cnt + k] = ext_ref(data_in[k*IW +: IW], sign_ext);
                    acc_cnt++;
                    m_cnt += LN;
                    if (m_cnt >= NP) begin
                        for (int i = 0; i < NP; i++) l[i*PW +: PW] = m_cur[i];
                        m_q.push_back(l);
                        m_cnt = 0;
                    end
                end
            end
        end
    end

    // Monitor: compare at the falling edge, then choose the next ack.
    initial begin
        forever begin
            @(negedge clk);
            check("in_ready", 128'(in_ready), 128'((m_q.size() < 2) && !clean));
            check("line_valid", 128'(line_valid), 128'(m_q.size() > 0));
            check("fill_level", 128'(fill_level), 128'(m_cnt));
            if (m_q.size() > 0)
                check("data_out", 128'(data_out), 128'(m_q[0]));
            if (ack_mode == 1)
                line_ack = ($urandom_range(0, 3) == 0);
            else if (ack_mode == 2) begin
                line_ack = 1'b1;
                ack_mode = 0;
            end else
                line_ack = 1'b0;
        end
    end

    task automatic send_word(input logic [31:0] d, input logic se);
        int start;
        bit done;
        start = acc_cnt;
        done  = 0;
        in_valid = 1'b1;
        data_in  = d;
        sign_ext = se;
        for (int c = 0; c < 50 && !done; c++) begin
            @(posedge clk); #1;
            if (acc_cnt != start) done = 1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL send_word: got no accept expected accept of %h", d);
        end
    endtask

    task automatic ack_once();
        ack_mode = 2;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [LW-1:0] exp_a;
        for (int i = 0; i < NP; i++) exp_a[i*PW +: PW] = PW'(i + 1);

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_line_valid", 128'(line_valid), 128'(0));
        check("rst_data_out", 128'(data_out), 128'(0));
        check("rst_fill", 128'(fill_level), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Line A: pixels 1..10, the top lanes of the last word dropped.
        send_word(32'h04030201, 1'b0);
        send_word(32'h08070605, 1'b0);
        send_word(32'hFFFF0A09, 1'b0);
        @(negedge clk);
        check("lineA_data", 128'(data_out), 128'(exp_a));
        check("lineA_valid", 128'(line_valid), 128'(1));
        @(posedge clk); #1;

        // Line B: sign/zero extension; both banks full afterwards.
        send_word(32'h80808080, 1'b1);
        send_word(32'h80808080, 1'b0);
        send_word(32'h00007F80, 1'b1);
        @(negedge clk);
        check("both_full_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        ack_once();
        @(negedge clk);
        check("lineB_px0", 128'(data_out[0 +: PW]), 128'(9'h180));
        check("lineB_px4", 128'(data_out[4*PW +: PW]), 128'(9'h080));
        check("lineB_px8", 128'(data_out[8*PW +: PW]), 128'(9'h180));
        check("lineB_px9", 128'(data_out[9*PW +: PW]), 128'(9'h07F));
        @(posedge clk); #1;

        // Line C completes in the same cycle that B is acked.
        send_word(32'h13121110, 1'b0);
        send_word(32'h17161514, 1'b0);
        ack_mode = 2;
        send_word(32'h00001918, 1'b0);
        @(negedge clk);
        check("simul_valid", 128'(line_valid), 128'(1));
        check("simul_px0", 128'(data_out[0 +: PW]), 128'(9'h010));
        @(posedge clk); #1;

        // Partial line D aborted by clean, then refilled from pixel 0.
        send_word(32'h5A5A5A5A, 1'b0);
        send_word(32'hA5A5A5A5, 1'b1);
        clean = 1'b1;
        @(posedge clk); #1;
        clean = 1'b0;
        @(negedge clk);
        check("clean_fill", 128'(fill_level), 128'(0));
        check("clean_held", 128'(data_out[0 +: PW]), 128'(9'h010));
        @(posedge clk); #1;
        send_word(32'h44332211, 1'b0);
        send_word(32'h88776655, 1'b0);
        send_word(32'h0000AA99, 1'b0);
        ack_once();
        @(negedge clk);
        check("lineD_px0", 128'(data_out[0 +: PW]), 128'(9'h011));
        @(posedge clk); #1;

        // Asynchronous reset mid-fill with one bank full.
        send_word(32'h01020304, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 128'(in_ready), 128'(1));
        check("arst_line_valid", 128'(line_valid), 128'(0));
        check("arst_data_out", 128'(data_out), 128'(0));
        check("arst_fill", 128'(fill_level), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomized traffic with random acks and occasional clean.
        ack_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            data_in  = ($urandom_range(0, 3) == 0) ? 32'h80FF7F80 : $urandom;
            sign_ext = 1'($urandom_range(0, 1));
            clean    = ($urandom_range(0, 31) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        clean    = 1'b0;
        ack_mode = 0;
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
